// File: rtl/lcd_hd44780_responder.sv
// Responder model for an 8-bit HD44780-style LCD bus: command decode, DDRAM/CGRAM images,
// busy-flag / address / RAM reads on the bus, plus a side readback port for screen checks.
module lcd_hd44780_responder #(
  parameter int unsigned DDRAM_SIZE = 128,
  parameter int unsigned CGRAM_SIZE = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lcd_rs,
  input  logic             lcd_rw,
  input  logic             lcd_en,
  input  logic [7:0]       lcd_data,
  output logic [7:0]       lcd_dout,
  output logic             lcd_dout_oe,
  input  logic             rb_sel,
  input  logic [6:0]       rb_addr,
  output logic [7:0]       rb_data,
  output logic             busy,
  output logic             disp_on,
  output logic             two_line,
  output logic [6:0]       ac,
  output logic             cgram_sel,
  output logic [CNT_W-1:0] cmd_count,
  output logic [CNT_W-1:0] data_count,
  output logic             err_busy
);
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 7;
  localparam int unsigned CW  = 6;
  localparam int unsigned SYW = DW + 3;

  typedef enum logic [1:0] {IDLE, CLEAR, READ} state_t;

  state_t           state_q, state_d;
  logic [SYW-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic             en_prev_q, en_prev_d;
  logic [AW-1:0]    clr_addr_q, clr_addr_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic             oe_q, oe_d;
  logic [DW-1:0]    rb_data_q, rb_data_d;
  logic             busy_q, busy_d;
  logic             disp_on_q, disp_on_d;
  logic             two_line_q, two_line_d;
  logic             id_inc_q, id_inc_d;
  logic [AW-1:0]    ac_q, ac_d;
  logic             cgram_sel_q, cgram_sel_d;
  logic [CNT_W-1:0] cmd_count_q, cmd_count_d;
  logic [CNT_W-1:0] data_count_q, data_count_d;
  logic             err_busy_q, err_busy_d;

  logic [DW-1:0]    ddram_q [DDRAM_SIZE];
  logic [DW-1:0]    cgram_q [CGRAM_SIZE];
  logic             dd_we, cg_we;
  logic [AW-1:0]    dd_waddr;
  logic [CW-1:0]    cg_waddr;
  logic [DW-1:0]    dd_wdata, cg_wdata;

  logic             s_en, s_rs, s_rw, strobe_c, rise_c;
  logic [DW-1:0]    s_data;
  logic [AW-1:0]    ac_step_c;

  assign {s_en, s_rs, s_rw, s_data} = sync2_q;
  assign strobe_c = en_prev_q & ~s_en;
  assign rise_c   = s_en & ~en_prev_q;

  // Address-counter step with the display's line-wrap rules.
  always_comb begin
    ac_step_c = ac_q;
    if (cgram_sel_q) begin
      ac_step_c = {1'b0, id_inc_q ? ac_q[CW-1:0] + 6'd1 : ac_q[CW-1:0] - 6'd1};
    end else if (two_line_q) begin
      if (id_inc_q) ac_step_c = (ac_q == 7'h27) ? 7'h40 : (ac_q == 7'h67) ? 7'h00 : ac_q + 7'd1;
      else          ac_step_c = (ac_q == 7'h00) ? 7'h67 : (ac_q == 7'h40) ? 7'h27 : ac_q - 7'd1;
    end else begin
      if (id_inc_q) ac_step_c = (ac_q == 7'h4F) ? 7'h00 : ac_q + 7'd1;
      else          ac_step_c = (ac_q == 7'h00) ? 7'h4F : ac_q - 7'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    sync1_d      = {lcd_en, lcd_rs, lcd_rw, lcd_data};
    sync2_d      = sync1_q;
    en_prev_d    = s_en;
    clr_addr_d   = clr_addr_q;
    dout_d       = dout_q;
    oe_d         = oe_q;
    busy_d       = busy_q;
    disp_on_d    = disp_on_q;
    two_line_d   = two_line_q;
    id_inc_d     = id_inc_q;
    ac_d         = ac_q;
    cgram_sel_d  = cgram_sel_q;
    cmd_count_d  = cmd_count_q;
    data_count_d = data_count_q;
    err_busy_d   = err_busy_q;
    dd_we        = 1'b0;
    dd_waddr     = ac_q;
    dd_wdata     = s_data;
    cg_we        = 1'b0;
    cg_waddr     = ac_q[CW-1:0];
    cg_wdata     = s_data;
    rb_data_d    = rb_sel ? cgram_q[rb_addr[CW-1:0]] : ddram_q[rb_addr];

    // Read window: capture the reply at en rising, release the bus at the strobe.
    if (rise_c && s_rw) begin
      oe_d   = 1'b1;
      dout_d = s_rs ? (cgram_sel_q ? cgram_q[ac_q[CW-1:0]] : ddram_q[ac_q]) : {busy_q, ac_q};
    end
    if (strobe_c) oe_d = 1'b0;

    case (state_q)
      CLEAR: begin
        dd_we      = 1'b1;
        dd_waddr   = clr_addr_q;
        dd_wdata   = 8'h20;
        clr_addr_d = clr_addr_q + 7'd1;
        if (strobe_c) err_busy_d = 1'b1;
        if (clr_addr_q == AW'(DDRAM_SIZE - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      IDLE: begin
        if (rise_c && s_rw) state_d = READ;
        if (strobe_c) begin
          if (s_rw) begin
            if (s_rs) ac_d = ac_step_c;
          end else if (s_rs) begin
            dd_we = ~cgram_sel_q;
            cg_we = cgram_sel_q;
            ac_d  = ac_step_c;
            if (data_count_q != '1) data_count_d = data_count_q + CNT_W'(1);
          end else begin
            if (cmd_count_q != '1) cmd_count_d = cmd_count_q + CNT_W'(1);
            casez (s_data)
              8'b1???????: begin ac_d = s_data[6:0]; cgram_sel_d = 1'b0; end
              8'b01??????: begin ac_d = {1'b0, s_data[5:0]}; cgram_sel_d = 1'b1; end
              8'b001?????: two_line_d = s_data[3];
              8'b0001????: ;
              8'b00001???: disp_on_d = s_data[2];
              8'b000001??: id_inc_d = s_data[1];
              8'b0000001?: begin ac_d = '0; cgram_sel_d = 1'b0; end
              8'b00000001: begin
                ac_d        = '0;
                cgram_sel_d = 1'b0;
                id_inc_d    = 1'b1;
                clr_addr_d  = '0;
                busy_d      = 1'b1;
                state_d     = CLEAR;
              end
              default: ;
            endcase
          end
        end
      end
      READ: begin
        if (strobe_c) begin
          state_d = IDLE;
          if (s_rs) ac_d = ac_step_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      sync1_q      <= '0;
      sync2_q      <= '0;
      en_prev_q    <= 1'b0;
      clr_addr_q   <= '0;
      dout_q       <= '0;
      oe_q         <= 1'b0;
      rb_data_q    <= '0;
      busy_q       <= 1'b1;
      disp_on_q    <= 1'b0;
      two_line_q   <= 1'b1;
      id_inc_q     <= 1'b1;
      ac_q         <= '0;
      cgram_sel_q  <= 1'b0;
      cmd_count_q  <= '0;
      data_count_q <= '0;
      err_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      en_prev_q    <= en_prev_d;
      clr_addr_q   <= clr_addr_d;
      dout_q       <= dout_d;
      oe_q         <= oe_d;
      rb_data_q    <= rb_data_d;
      busy_q       <= busy_d;
      disp_on_q    <= disp_on_d;
      two_line_q   <= two_line_d;
      id_inc_q     <= id_inc_d;
      ac_q         <= ac_d;
      cgram_sel_q  <= cgram_sel_d;
      cmd_count_q  <= cmd_count_d;
      data_count_q <= data_count_d;
      err_busy_q   <= err_busy_d;
    end
  end

  // RAM images carry no reset; CLEAR initialises DDRAM.
  always_ff @(posedge clk) begin
    if (!rst && dd_we) ddram_q[dd_waddr] <= dd_wdata;
    if (!rst && cg_we) cgram_q[cg_waddr] <= cg_wdata;
  end

  assign lcd_dout    = dout_q;
  assign lcd_dout_oe = oe_q;
  assign rb_data     = rb_data_q;
  assign busy        = busy_q;
  assign disp_on     = disp_on_q;
  assign two_line    = two_line_q;
  assign ac          = ac_q;
  assign cgram_sel   = cgram_sel_q;
  assign cmd_count   = cmd_count_q;
  assign data_count  = data_count_q;
  assign err_busy    = err_busy_q;
endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for lcd_hd44780_responder: vector table of bus writes plus
// hand sequences for CLEAR timing, bus reads, busy errors and mid-CLEAR reset.
module tb_lcd_hd44780_responder;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
  logic [7:0]       lcd_data = '0;
  logic [7:0]       lcd_dout;
  logic             lcd_dout_oe;
  logic             rb_sel = 1'b0;
  logic [6:0]       rb_addr = '0;
  logic [7:0]       rb_data;
  logic             busy, disp_on, two_line, cgram_sel, err_busy;
  logic [6:0]       ac;
  logic [CNT_W-1:0] cmd_count, data_count;

  int n_cmp = 0;
  int n_err = 0;

  lcd_hd44780_responder #(.DDRAM_SIZE(128), .CGRAM_SIZE(64), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data(lcd_data), .lcd_dout(lcd_dout), .lcd_dout_oe(lcd_dout_oe),
    .rb_sel(rb_sel), .rb_addr(rb_addr), .rb_data(rb_data), .busy(busy),
    .disp_on(disp_on), .two_line(two_line), .ac(ac), .cgram_sel(cgram_sel),
    .cmd_count(cmd_count), .data_count(data_count), .err_busy(err_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic [6:0] ac;
    int         cmd;
    int         dat;
    logic       disp;
    logic       two;
    logic       cg;
  } vec_t;

  typedef struct {
    logic       sel;
    logic [6:0] addr;
    logic [7:0] exp;
  } rb_t;

  vec_t vecs[27];
  rb_t  rbs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic rs, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b0; lcd_data = d; lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    lcd_en = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic bus_rd(input logic rs, input logic [7:0] exp, input string name);
    @(negedge clk);
    chk({name, "_oe_before"}, 32'(lcd_dout_oe), 0);
    lcd_rs = rs; lcd_rw = 1'b1; lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    chk({name, "_oe_window"}, 32'(lcd_dout_oe), 1);
    chk({name, "_dout"}, 32'(lcd_dout), 32'(exp));
    lcd_en = 1'b0;
    @(negedge clk);
    chk({name, "_oe_until_strobe"}, 32'(lcd_dout_oe), 1);
    chk({name, "_dout_stable"}, 32'(lcd_dout), 32'(exp));
    repeat (5) @(negedge clk);
    chk({name, "_oe_after"}, 32'(lcd_dout_oe), 0);
    lcd_rw = 1'b0;
  endtask

  task automatic rb_chk(input logic sel, input logic [6:0] addr, input logic [7:0] exp);
    @(negedge clk);
    rb_sel = sel; rb_addr = addr;
    @(negedge clk);
    chk($sformatf("rb_%s_%02h", sel ? "cg" : "dd", addr), 32'(rb_data), 32'(exp));
  endtask

  task automatic wait_idle(input int exp_cyc, input string name);
    int n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_cyc >= 0) chk(name, n, exp_cyc);
    else              chk(name, 32'(busy), 0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 8'h38, 7'h00, 1, 0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'h0C, 7'h00, 2, 0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h06, 7'h00, 3, 0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h80, 7'h00, 4, 0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 8'h41, 7'h01, 4, 1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 8'h42, 7'h02, 4, 2, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'hA7, 7'h27, 5, 2, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'h55, 7'h40, 5, 3, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 8'h66, 7'h41, 5, 4, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h78, 7'h38, 6, 4, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 8'h01, 7'h39, 6, 5, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 8'h02, 7'h3A, 6, 6, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 8'h03, 7'h3B, 6, 7, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 8'h04, 7'h3C, 6, 8, 1'b1, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 8'h05, 7'h3D, 6, 9, 1'b1, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 8'h06, 7'h3E, 6, 10, 1'b1, 1'b1, 1'b1};
    vecs[16] = '{1'b1, 8'h07, 7'h3F, 6, 11, 1'b1, 1'b1, 1'b1};
    vecs[17] = '{1'b1, 8'h08, 7'h00, 6, 12, 1'b1, 1'b1, 1'b1};
    vecs[18] = '{1'b1, 8'h09, 7'h01, 6, 13, 1'b1, 1'b1, 1'b1};
    vecs[19] = '{1'b0, 8'h04, 7'h01, 7, 13, 1'b1, 1'b1, 1'b1};
    vecs[20] = '{1'b0, 8'h80, 7'h00, 8, 13, 1'b1, 1'b1, 1'b0};
    vecs[21] = '{1'b1, 8'h77, 7'h67, 8, 14, 1'b1, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 8'h06, 7'h67, 9, 14, 1'b1, 1'b1, 1'b0};
    vecs[23] = '{1'b0, 8'h30, 7'h67, 10, 14, 1'b1, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 8'hCF, 7'h4F, 11, 14, 1'b1, 1'b0, 1'b0};
    vecs[25] = '{1'b1, 8'h88, 7'h00, 11, 15, 1'b1, 1'b0, 1'b0};
    vecs[26] = '{1'b0, 8'h02, 7'h00, 12, 15, 1'b1, 1'b0, 1'b0};

    rbs[0] = '{1'b0, 7'h00, 8'h77};
    rbs[1] = '{1'b0, 7'h01, 8'h42};
    rbs[2] = '{1'b0, 7'h27, 8'h55};
    rbs[3] = '{1'b0, 7'h40, 8'h66};
    rbs[4] = '{1'b0, 7'h4F, 8'h88};
    rbs[5] = '{1'b0, 7'h41, 8'h20};
    rbs[6] = '{1'b1, 7'h38, 8'h01};
    rbs[7] = '{1'b1, 7'h3F, 8'h08};
    rbs[8] = '{1'b1, 7'h00, 8'h09};

    // Reset values, then CLEAR length and blanked DDRAM.
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_two_line", 32'(two_line), 1);
    chk("rst_disp_on", 32'(disp_on), 0);
    chk("rst_ac", 32'(ac), 0);
    chk("rst_cmd_count", 32'(cmd_count), 0);
    chk("rst_err_busy", 32'(err_busy), 0);
    chk("rst_oe", 32'(lcd_dout_oe), 0);
    rst = 1'b0;
    wait_idle(128, "clear_cycles");
    rb_chk(1'b0, 7'h00, 8'h20);
    rb_chk(1'b0, 7'h7F, 8'h20);

    foreach (vecs[i]) begin
      bus_wr(vecs[i].rs, vecs[i].d);
      chk($sformatf("v%0d_ac", i), 32'(ac), 32'(vecs[i].ac));
      chk($sformatf("v%0d_cmd_count", i), 32'(cmd_count), 32'(vecs[i].cmd));
      chk($sformatf("v%0d_data_count", i), 32'(data_count), 32'(vecs[i].dat));
      chk($sformatf("v%0d_disp_on", i), 32'(disp_on), 32'(vecs[i].disp));
      chk($sformatf("v%0d_two_line", i), 32'(two_line), 32'(vecs[i].two));
      chk($sformatf("v%0d_cgram_sel", i), 32'(cgram_sel), 32'(vecs[i].cg));
      chk($sformatf("v%0d_busy", i), 32'(busy), 0);
    end
    foreach (rbs[i]) rb_chk(rbs[i].sel, rbs[i].addr, rbs[i].exp);
    chk("no_err_yet", 32'(err_busy), 0);

    // Bus reads: address counter, then RAM byte with AC step.
    bus_wr(1'b0, 8'hC5);
    bus_rd(1'b0, 8'h45, "rd_ac");
    chk("rd_ac_unchanged", 32'(ac), 32'h45);
    bus_wr(1'b0, 8'hA7);
    bus_rd(1'b1, 8'h55, "rd_ram");
    chk("rd_ram_ac_step", 32'(ac), 32'h28);
    chk("rd_cmd_count", 32'(cmd_count), 14);
    chk("rd_data_count", 32'(data_count), 15);

    // Clear display followed at once by a data write that must be dropped.
    bus_wr(1'b0, 8'h01);
    bus_wr(1'b1, 8'h33);
    chk("clr_busy", 32'(busy), 1);
    chk("clr_err_busy", 32'(err_busy), 1);
    chk("clr_data_count", 32'(data_count), 15);
    bus_rd(1'b0, 8'h80, "rd_busy");
    wait_idle(-1, "clr_done");
    chk("clr_ac", 32'(ac), 0);
    chk("clr_cmd_count", 32'(cmd_count), 15);
    chk("clr_err_sticky", 32'(err_busy), 1);
    rb_chk(1'b0, 7'h27, 8'h20);
    rb_chk(1'b0, 7'h00, 8'h20);

    // Reset in the middle of CLEAR restarts the full sequence.
    bus_wr(1'b0, 8'h01);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_err_busy", 32'(err_busy), 0);
    chk("mid_rst_cmd_count", 32'(cmd_count), 0);
    chk("mid_rst_data_count", 32'(data_count), 0);
    chk("mid_rst_two_line", 32'(two_line), 1);
    chk("mid_rst_busy", 32'(busy), 1);
    rst = 1'b0;
    wait_idle(128, "mid_rst_clear_cycles");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
